// File: rtl/ps2_host_tx_if.sv
// Bus-side handshake between the PS/2 host transmitter and its controller.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       error;
  logic       rx_inhibit;

  modport master (
    output tx_data,
    output tx_start,
    input  busy,
    input  done,
    input  error,
    input  rx_inhibit
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output busy,
    output done,
    output error,
    output rx_inhibit
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10-bit frame, device ACK,
// with inter-edge timeout. Pins are only ever pulled low through the *_oe enables.
module ps2_host_tx #(
  parameter logic [15:0] INHIBIT_CYCLES = 16'd1000,
  parameter logic [15:0] SETUP_CYCLES   = 16'd16,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd30000
) (
  input  logic          clock,
  input  logic          reset_n,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clock_in,
  input  logic          ps2_data_in,
  output logic          ps2_clock_oe,
  output logic          ps2_data_oe
);

  typedef enum logic [2:0] {StIdle, StInhibit, StRts, StSend, StAck, StWaitIdle} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [9:0]  shift_q, shift_d;
  logic        data_oe_q, data_oe_d;
  logic        ack_ok_q, ack_ok_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  clk_sync_q, data_sync_q;
  logic        clk_prev_q;

  logic        fall;
  logic [15:0] cnt_inc;
  logic        timeout;

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign timeout = (cnt_inc >= TIMEOUT_CYCLES);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      data_oe_q   <= 1'b0;
      ack_ok_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      data_oe_q   <= data_oe_d;
      ack_ok_q    <= ack_ok_d;
      done_q      <= done_d;
      error_q     <= error_d;
      clk_sync_q  <= {clk_sync_q[0], ps2_clock_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    data_oe_d = data_oe_q;
    ack_ok_d  = ack_ok_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        data_oe_d = 1'b0;
        // A start in the completion-pulse cycle is refused so pulses never overlap acceptance.
        if (bus.tx_start && !done_q && !error_q) begin
          shift_d = {1'b1, ~^bus.tx_data, bus.tx_data};
          cnt_d   = '0;
          state_d = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_inc >= INHIBIT_CYCLES) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = StRts;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRts: begin
        if (cnt_inc >= SETUP_CYCLES) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = StSend;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StSend: begin
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[9:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          cnt_d     = '0;
          if (bitcnt_q == 4'd9) state_d = StAck;
        end else if (timeout) begin
          state_d   = StIdle;
          data_oe_d = 1'b0;
          cnt_d     = '0;
          error_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StAck: begin
        data_oe_d = 1'b0;
        if (fall) begin
          ack_ok_d = ~data_sync_q[1];
          cnt_d    = '0;
          state_d  = StWaitIdle;
        end else if (timeout) begin
          state_d = StIdle;
          cnt_d   = '0;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitIdle: begin
        data_oe_d = 1'b0;
        if (clk_sync_q[1] && data_sync_q[1]) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = ack_ok_q;
          error_d = ~ack_ok_q;
        end else if (timeout) begin
          state_d = StIdle;
          cnt_d   = '0;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d   = StIdle;
        data_oe_d = 1'b0;
      end
    endcase
  end

  assign ps2_clock_oe   = (state_q == StInhibit) || (state_q == StRts);
  assign ps2_data_oe    = data_oe_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.rx_inhibit = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule
